sevenseg_value_decoder: RTL and testbench

- Converts a bank of seven-segment digit patterns back into a binary seconds count.
- It is the decoder for the stopwatch display encoder: it accepts the same `NUM_OF_7SEGS * 8`-bit active-low pattern bus the top level drives.
- Conversion is digit-serial: one pattern is validated and accumulated per clock, most significant digit first, and the result is reported with a one-cycle `done` pulse.
- Intended uses are display loopback checking and preset entry from a captured display image.

---
 rtl/sevenseg_value_decoder.sv | 119 +++++++++++
 tb/tb_sevenseg_value_decoder.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/sevenseg_value_decoder.sv
// Digit-serial decoder: active-low seven-segment pattern bank -> binary seconds, MSD first.
// Latency NUM_OF_7SEGS+1 cycles from start to done pulse; no backpressure, start ignored unless idle.
module sevenseg_value_decoder #(
  parameter int SECONDS_WIDTH = 10,
  parameter int NUM_OF_7SEGS  = 4
) (
  input  logic                        clk,
  input  logic                        async_reset,
  input  logic                        start,
  input  logic [NUM_OF_7SEGS*8-1:0]   seconds_passed_7segs,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [SECONDS_WIDTH-1:0]    seconds_value
);

  localparam int BUS_W = NUM_OF_7SEGS * 8;
  localparam int ACC_W = SECONDS_WIDTH + 4;
  localparam int CNT_W = (NUM_OF_7SEGS > 1) ? $clog2(NUM_OF_7SEGS) : 1;

  localparam logic [ACC_W-1:0] ACC_MAX  = {4'b0000, {SECONDS_WIDTH{1'b1}}};
  localparam logic [ACC_W-1:0] ACC_TEN  = ACC_W'(10);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_OF_7SEGS - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]       state;
  logic [BUS_W-1:0] shift_reg;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic             inv_flag;
  logic             ovf_flag;

  logic [7:0]       digit_pat;
  logic             dec_valid;
  logic [3:0]       dec_digit;
  logic [ACC_W-1:0] acc_sum;
  logic             ovf_now;
  logic [ACC_W-1:0] acc_nxt;
  logic             inv_nxt;
  logic             ovf_nxt;

  // Decimal point (bit 7) must be off; anything outside the table is invalid.
  always_comb begin
    dec_valid = 1'b1;
    dec_digit = 4'd0;
    case (digit_pat)
      8'hC0:   dec_digit = 4'd0;
      8'hF9:   dec_digit = 4'd1;
      8'hA4:   dec_digit = 4'd2;
      8'hB0:   dec_digit = 4'd3;
      8'h99:   dec_digit = 4'd4;
      8'h92:   dec_digit = 4'd5;
      8'h82:   dec_digit = 4'd6;
      8'hF8:   dec_digit = 4'd7;
      8'h80:   dec_digit = 4'd8;
      8'h90:   dec_digit = 4'd9;
      default: dec_valid = 1'b0;
    endcase
  end

  assign digit_pat = shift_reg[BUS_W-1 -: 8];
  assign acc_sum   = acc * ACC_TEN + ACC_W'(dec_digit);
  assign ovf_now   = acc_sum > ACC_MAX;
  assign acc_nxt   = ovf_now ? ACC_MAX : acc_sum;
  assign inv_nxt   = inv_flag | ~dec_valid;
  assign ovf_nxt   = ovf_flag | ovf_now;

  assign busy  = (state == ST_DECODE);
  assign done  = (state == ST_DONE);
  assign error = done & (inv_flag | ovf_flag);

  always_ff @(posedge clk) begin
    if (async_reset) begin
      state         <= ST_IDLE;
      shift_reg     <= '0;
      cnt           <= '0;
      acc           <= '0;
      inv_flag      <= 1'b0;
      ovf_flag      <= 1'b0;
      seconds_value <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            shift_reg <= seconds_passed_7segs;
            cnt       <= '0;
            acc       <= '0;
            inv_flag  <= 1'b0;
            ovf_flag  <= 1'b0;
            state     <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          shift_reg <= shift_reg << 8;
          cnt       <= cnt + CNT_W'(1);
          acc       <= acc_nxt;
          inv_flag  <= inv_nxt;
          ovf_flag  <= ovf_nxt;
          // Result is registered on the last digit so it lines up with the done cycle.
          if (cnt == CNT_LAST) begin
            state <= ST_DONE;
            if (inv_nxt)
              seconds_value <= '0;
            else if (ovf_nxt)
              seconds_value <= '1;
            else
              seconds_value <= acc_nxt[SECONDS_WIDTH-1:0];
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sevenseg_value_decoder.sv
// Scoreboard bench: stimulus pushes expected results, a negedge monitor pops them on done.
module tb_sevenseg_value_decoder;

  localparam int SW = 10;
  localparam int N  = 4;

  typedef struct {
    logic [SW-1:0] value;
    logic          err;
    int            cyc;
  } exp_t;

  logic            clk = 1'b0;
  logic            async_reset = 1'b1;
  logic            start = 1'b0;
  logic [N*8-1:0]  pattern = '0;
  logic            busy;
  logic            done;
  logic            error;
  logic [SW-1:0]   seconds_value;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  sevenseg_value_decoder #(.SECONDS_WIDTH(SW), .NUM_OF_7SEGS(N)) dut (
    .clk                  (clk),
    .async_reset          (async_reset),
    .start                (start),
    .seconds_passed_7segs (pattern),
    .busy                 (busy),
    .done                 (done),
    .error                (error),
    .seconds_value        (seconds_value)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic push_exp(input logic [SW-1:0] v, input logic e, input int c);
    exp_t x;
    x.value = v;
    x.err   = e;
    x.cyc   = c;
    exp_q.push_back(x);
  endtask

  // Monitor: protocol invariants every cycle, result comparison on done.
  always @(negedge clk) begin
    if (busy || done || error) begin
      check("busy_done_exclusive", int'(busy && done), 0);
      check("error_only_with_done", int'(error && !done), 0);
    end
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        check("seconds_value", int'(seconds_value), int'(x.value));
        check("error", int'(error), int'(x.err));
        check("done_latency_cycle", cyc, x.cyc);
      end
    end
  end

  // One conversion at full throughput; the bus is scrambled right after capture.
  task automatic do_conv(input logic [N*8-1:0] bus, input logic [SW-1:0] v, input logic e);
    @(negedge clk);
    push_exp(v, e, cyc + 1 + N);
    pattern = bus;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    pattern = ~bus;
    check("busy_decode", int'(busy), 1);
    for (int i = 1; i < N; i++) begin
      @(negedge clk);
      check("busy_decode", int'(busy), 1);
    end
    @(negedge clk);
    check("busy_low_in_done", int'(busy), 0);
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_error", int'(error), 0);
    check("rst_value", int'(seconds_value), 0);
    async_reset = 1'b0;

    do_conv(32'hC0F9_A4B0, 10'd123,  1'b0);
    do_conv(32'hF9C0_A4B0, 10'd1023, 1'b0);
    do_conv(32'hF9C0_A499, 10'd1023, 1'b1);
    do_conv(32'h9090_FF90, 10'd0,    1'b1);
    do_conv(32'h9090_9040, 10'd0,    1'b1);
    do_conv(32'h9090_9090, 10'd1023, 1'b1);
    do_conv(32'hC0C0_C0C0, 10'd0,    1'b0);
    do_conv(32'hC090_80F8, 10'd987,  1'b0);

    // start held high: back-to-back conversions every N+2 cycles, bus changes mid-DECODE ignored.
    @(negedge clk);
    push_exp(10'd456, 1'b0, cyc + 1 + N);
    push_exp(10'd42,  1'b0, cyc + 1 + N + (N + 2));
    pattern = 32'hC099_9282;
    start   = 1'b1;
    @(negedge clk);
    pattern = 32'hC0C0_99A4;
    repeat (7) @(negedge clk);
    start   = 1'b0;
    pattern = 32'hFFFF_FFFF;
    repeat (6) @(negedge clk);

    // Reset together with start: reset wins and nothing is captured.
    @(negedge clk);
    async_reset = 1'b1;
    start       = 1'b1;
    pattern     = 32'hC0F9_A4B0;
    @(negedge clk);
    async_reset = 1'b0;
    start       = 1'b0;
    check("rst_start_busy", int'(busy), 0);
    @(negedge clk);
    check("rst_start_no_capture", int'(busy), 0);

    // Prime a nonzero result, then abort the next conversion in its second DECODE cycle.
    do_conv(32'hC0C0_99A4, 10'd42, 1'b0);
    @(negedge clk);
    pattern = 32'hC090_80F8;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    @(negedge clk);
    check("abort_busy_before_reset", int'(busy), 1);
    async_reset = 1'b1;
    @(negedge clk);
    async_reset = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_error", int'(error), 0);
    check("abort_value", int'(seconds_value), 0);
    repeat (N + 3) @(negedge clk);
    check("abort_value_held", int'(seconds_value), 0);

    do_conv(32'hC082_C080, 10'd608, 1'b0);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
